mem_arb2: RTL and testbench

Two-requester arbiter sharing one single-port, word-addressed testbench memory (ready/we/wstrb request, rresp/rdata read response one cycle later). Sits between the core's instruction-fetch port (m0) and data port (m1) and the shared memory. Issues at most one request per cycle, steers each read response to its issuer, and flags protocol violations.

---
 rtl/mem_arb_pkg.sv | 32 +++
 rtl/arb2_rr.sv | 70 +++++++
 rtl/mem_arb2.sv | 128 ++++++++++++
 tb/tb_mem_arb2.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Shared constants and types for the two-requester memory arbiter.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  // Bus geometry: word address [31:2], 32-bit data, byte strobes.
  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  // Arbitration modes.
  localparam bit ARB_FIXED = 1'b0;  // m1 always wins contention
  localparam bit ARB_RR    = 1'b1;  // the requester not granted last wins

  // Requester index encoding.
  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } req_idx_e;

  // The requester that is not idx.
  function automatic req_idx_e other_req(input req_idx_e idx);
    return (idx == M0) ? M1 : M0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arb2_rr.sv
// ----------------------------------------------------------------------------
// arb2_rr
// Two-way combinational grant logic with a last-granted register.
// Fixed mode gives contention to m1; round-robin mode gives it to the
// requester that was not granted most recently.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module arb2_rr
  import mem_arb_pkg::*;
#(
  parameter bit ARB_MODE = ARB_RR
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     req0_i,
  input  logic     req1_i,
  output logic     gnt0_o,
  output logic     gnt1_o,
  output req_idx_e winner_o
);

  req_idx_e last_gnt_q;
  req_idx_e last_gnt_d;

  // Grant decision; both grants are held low while reset is asserted.
  always_comb begin
    gnt0_o   = 1'b0;
    gnt1_o   = 1'b0;
    winner_o = M0;
    if (rst_ni) begin
      if (req0_i && req1_i) begin
        if (ARB_MODE == ARB_FIXED) begin
          winner_o = M1;
        end else begin
          winner_o = other_req(last_gnt_q);
        end
        gnt0_o = (winner_o == M0);
        gnt1_o = (winner_o == M1);
      end else if (req1_i) begin
        winner_o = M1;
        gnt1_o   = 1'b1;
      end else if (req0_i) begin
        winner_o = M0;
        gnt0_o   = 1'b1;
      end
    end
  end

  // Remember every winner, contended or not.
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt0_o || gnt1_o) begin
      last_gnt_d = winner_o;
    end
  end

  // last_gnt register; resets to m0 so m1 wins the first contention.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_gnt_q <= M0;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arb2.sv
// ----------------------------------------------------------------------------
// mem_arb2
// Shares one single-port memory between an instruction-fetch requester (m0)
// and a data requester (m1). Issues at most one request per cycle, steers
// each one-cycle-latency read response back to its issuer and raises a
// sticky error on unexpected or missing read responses.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_arb2
  import mem_arb_pkg::*;
#(
  parameter bit ARB_MODE = ARB_RR
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // requester m0 (instruction fetch)
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:2] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_wstrb_i,
  output logic        m0_gnt_o,
  output logic        m0_rresp_o,
  output logic [31:0] m0_rdata_o,
  // requester m1 (data)
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:2] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_wstrb_i,
  output logic        m1_gnt_o,
  output logic        m1_rresp_o,
  output logic [31:0] m1_rdata_o,
  // shared memory
  output logic        mem_ready_o,
  output logic        mem_we_o,
  output logic [31:2] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_rresp_i,
  input  logic [31:0] mem_rdata_i,
  // status
  output logic        err_o
);

  req_idx_e winner;
  logic     gnt_any;
  logic     rd_issue;

  logic     rd_pend_q,  rd_pend_d;
  req_idx_e rd_owner_q, rd_owner_d;
  logic     err_q,      err_d;

  arb2_rr #(
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req0_i   (m0_req_i),
    .req1_i   (m1_req_i),
    .gnt0_o   (m0_gnt_o),
    .gnt1_o   (m1_gnt_o),
    .winner_o (winner)
  );

  assign gnt_any = m0_gnt_o | m1_gnt_o;

  // Request mux: m1 fields only when m1 holds the grant, m0 fields otherwise.
  always_comb begin
    mem_ready_o = gnt_any;
    mem_we_o    = m0_we_i;
    mem_addr_o  = m0_addr_i;
    mem_wdata_o = m0_wdata_i;
    mem_wstrb_o = m0_wstrb_i;
    if (m1_gnt_o) begin
      mem_we_o    = m1_we_i;
      mem_addr_o  = m1_addr_i;
      mem_wdata_o = m1_wdata_i;
      mem_wstrb_o = m1_wstrb_i;
    end
  end

  assign rd_issue = gnt_any & ~mem_we_o;

  // Read tracking and error detection: a response is owed exactly one cycle
  // after each granted read; anything else is a protocol violation.
  always_comb begin
    rd_pend_d  = rd_issue;
    rd_owner_d = rd_issue ? winner : rd_owner_q;
    err_d      = err_q
               | (mem_rresp_i & ~rd_pend_q)
               | (rd_pend_q & ~mem_rresp_i);
  end

  // Tracking and sticky-error state; reset drops any pending response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= M0;
      err_q      <= 1'b0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      err_q      <= err_d;
    end
  end

  // Response steering: only the owner of the outstanding read sees it.
  always_comb begin
    m0_rresp_o = mem_rresp_i & rd_pend_q & (rd_owner_q == M0);
    m1_rresp_o = mem_rresp_i & rd_pend_q & (rd_owner_q == M1);
    m0_rdata_o = m0_rresp_o ? mem_rdata_i : 32'h0;
    m1_rdata_o = m1_rresp_o ? mem_rdata_i : 32'h0;
  end

  assign err_o = err_q;

  // Structural invariants: grants and responses are never both high.
  a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(m0_gnt_o && m1_gnt_o));
  a_rresp_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(m0_rresp_o && m1_rresp_o));

endmodule

`default_nettype wire

// File: tb/tb_mem_arb2.sv
// ----------------------------------------------------------------------------
// tb_mem_arb2
// Bench for mem_arb2: a round-robin instance with a behavioural memory and
// a response scoreboard, plus a fixed-priority instance for grant checks.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_arb2;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:2] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;

  // round-robin instance
  logic        rr_m0_gnt, rr_m1_gnt, rr_m0_rresp, rr_m1_rresp;
  logic [31:0] rr_m0_rdata, rr_m1_rdata;
  logic        rr_mem_ready, rr_mem_we, rr_err;
  logic [31:2] rr_mem_addr;
  logic [31:0] rr_mem_wdata;
  logic [3:0]  rr_mem_wstrb;
  logic        mem_rresp;
  logic [31:0] mem_rdata;

  // fixed-priority instance (memory side idle)
  logic        fx_m0_gnt, fx_m1_gnt, fx_m0_rresp, fx_m1_rresp;
  logic [31:0] fx_m0_rdata, fx_m1_rdata;
  logic        fx_mem_ready, fx_mem_we, fx_err;
  logic [31:2] fx_mem_addr;
  logic [31:0] fx_mem_wdata;
  logic [3:0]  fx_mem_wstrb;

  mem_arb2 #(.ARB_MODE(ARB_RR)) u_rr (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_wstrb_i(m0_wstrb), .m0_gnt_o(rr_m0_gnt), .m0_rresp_o(rr_m0_rresp), .m0_rdata_o(rr_m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_wstrb_i(m1_wstrb), .m1_gnt_o(rr_m1_gnt), .m1_rresp_o(rr_m1_rresp), .m1_rdata_o(rr_m1_rdata),
    .mem_ready_o(rr_mem_ready), .mem_we_o(rr_mem_we), .mem_addr_o(rr_mem_addr),
    .mem_wdata_o(rr_mem_wdata), .mem_wstrb_o(rr_mem_wstrb),
    .mem_rresp_i(mem_rresp), .mem_rdata_i(mem_rdata), .err_o(rr_err)
  );

  mem_arb2 #(.ARB_MODE(ARB_FIXED)) u_fx (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_wstrb_i(m0_wstrb), .m0_gnt_o(fx_m0_gnt), .m0_rresp_o(fx_m0_rresp), .m0_rdata_o(fx_m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_wstrb_i(m1_wstrb), .m1_gnt_o(fx_m1_gnt), .m1_rresp_o(fx_m1_rresp), .m1_rdata_o(fx_m1_rdata),
    .mem_ready_o(fx_mem_ready), .mem_we_o(fx_mem_we), .mem_addr_o(fx_mem_addr),
    .mem_wdata_o(fx_mem_wdata), .mem_wstrb_o(fx_mem_wstrb),
    .mem_rresp_i(1'b0), .mem_rdata_i(32'h0), .err_o(fx_err)
  );

  // ---------------- behavioural memory (one-cycle read latency) ----------
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic        mdl_rresp = 1'b0;
  logic [31:0] mdl_rdata = 32'h0;
  logic        force_rresp = 1'b0;
  logic        drop_rresp  = 1'b0;

  always @(posedge clk) begin
    mdl_rresp <= 1'b0;
    if (rr_mem_ready) begin
      if (rr_mem_we) begin
        for (int b = 0; b < 4; b++)
          if (rr_mem_wstrb[b]) mem[rr_mem_addr[9:2]][8*b +: 8] <= rr_mem_wdata[8*b +: 8];
      end else begin
        mdl_rresp <= 1'b1;
        mdl_rdata <= mem[rr_mem_addr[9:2]];
      end
    end
  end

  assign mem_rresp = (mdl_rresp & ~drop_rresp) | force_rresp;
  assign mem_rdata = mdl_rresp ? mdl_rdata : 32'h0;

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        owner;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  logic sb_en = 1'b1;

  // Scoreboard monitor: every read response must match the oldest expectation.
  always @(negedge clk) begin
    if (sb_en && (rr_m0_rresp || rr_m1_rresp)) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_rresp", {30'b0, rr_m1_rresp, rr_m0_rresp}, 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_rresp_owner", {30'b0, rr_m1_rresp, rr_m0_rresp}, e.owner ? 32'd2 : 32'd1);
        check("sb_rdata", e.owner ? rr_m1_rdata : rr_m0_rdata, e.data);
        check("sb_idle_rdata", e.owner ? rr_m0_rdata : rr_m1_rdata, 32'h0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic req, input logic we, input logic [31:2] a,
                          input logic [31:0] d, input logic [3:0] s);
    m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; m0_wstrb = s;
  endtask

  task automatic drive_m1(input logic req, input logic we, input logic [31:2] a,
                          input logic [31:0] d, input logic [3:0] s);
    m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; m1_wstrb = s;
  endtask

  task automatic ref_write(input logic [31:2] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic push(input logic owner, input logic [31:0] data);
    exp_t e;
    e.owner = owner;
    e.data  = data;
    sb_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i0, i1;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'h5A000000 ^ (i * 32'h00010307);
      ref_mem[i] = 32'h5A000000 ^ (i * 32'h00010307);
    end
    mem[8'h40] = 32'hDEADBEEF;  ref_mem[8'h40] = 32'hDEADBEEF;  // byte 0x100
    mem[8'h10] = 32'hAABBCCDD;  ref_mem[8'h10] = 32'hAABBCCDD;  // byte 0x40

    // ---- reset: requests asserted but nothing may be granted ----
    rst_n = 1'b0;
    drive_m0(1'b1, 1'b0, 30'h1, 32'h0, 4'h0);
    drive_m1(1'b1, 1'b0, 30'h2, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m0_gnt", 32'(rr_m0_gnt), 32'h0);
    check("rst_m1_gnt", 32'(rr_m1_gnt), 32'h0);
    check("rst_mem_ready", 32'(rr_mem_ready), 32'h0);
    check("rst_err", 32'(rr_err), 32'h0);
    check("rst_rresp", {30'b0, rr_m1_rresp, rr_m0_rresp}, 32'h0);
    check("rst_rdata", rr_m0_rdata | rr_m1_rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_m0(1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    drive_m1(1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    tick();

    // ---- single read: m0 reads byte 0x100 ----
    drive_m0(1'b1, 1'b0, 30'h40, 32'h0, 4'h0);
    push(1'b0, 32'hDEADBEEF);
    @(negedge clk);
    check("rd_m0_gnt", 32'(rr_m0_gnt), 32'h1);
    check("rd_m1_gnt", 32'(rr_m1_gnt), 32'h0);
    check("rd_mem_ready", 32'(rr_mem_ready), 32'h1);
    check("rd_mem_addr", {2'b0, rr_mem_addr}, 32'h40);
    tick();
    m0_req = 1'b0;
    @(negedge clk);
    check("rd_m0_rresp_n1", 32'(rr_m0_rresp), 32'h1);
    check("rd_m1_rresp_n1", 32'(rr_m1_rresp), 32'h0);
    tick();
    @(negedge clk);
    check("rd_m0_rresp_n2", 32'(rr_m0_rresp), 32'h0);
    tick();

    // ---- round-robin contention: both read for 6 cycles ----
    i0 = 0; i1 = 0;
    for (int k = 0; k < 6; k++) begin
      drive_m0(1'b1, 1'b0, 30'(32'h80 + i0), 32'h0, 4'h0);
      drive_m1(1'b1, 1'b0, 30'(32'hC0 + i1), 32'h0, 4'h0);
      if (k % 2 == 0) push(1'b1, ref_mem[8'(32'hC0 + i1)]);
      else            push(1'b0, ref_mem[8'(32'h80 + i0)]);
      @(negedge clk);
      check($sformatf("rr_m1_gnt[%0d]", k), 32'(rr_m1_gnt), (k % 2 == 0) ? 32'h1 : 32'h0);
      check($sformatf("rr_m0_gnt[%0d]", k), 32'(rr_m0_gnt), (k % 2 == 0) ? 32'h0 : 32'h1);
      tick();
      if (k % 2 == 0) i1++; else i0++;
    end
    drive_m0(1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    drive_m1(1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    tick();
    tick();
    check("rr_err", 32'(rr_err), 32'h0);

    // ---- fixed priority: m1 wins for 4 cycles, m0 after m1 drops ----
    sb_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_m0(1'b1, 1'b0, 30'h20, 32'h0, 4'h0);
      drive_m1(1'b1, 1'b0, 30'h21, 32'h0, 4'h0);
      @(negedge clk);
      check($sformatf("fx_m1_gnt[%0d]", k), 32'(fx_m1_gnt), 32'h1);
      check($sformatf("fx_m0_gnt[%0d]", k), 32'(fx_m0_gnt), 32'h0);
      tick();
    end
    m1_req = 1'b0;
    @(negedge clk);
    check("fx_m0_gnt_after", 32'(fx_m0_gnt), 32'h1);
    tick();
    m0_req = 1'b0;
    tick();
    tick();
    sb_en = 1'b1;

    // ---- write then read: partial strobes ----
    drive_m1(1'b1, 1'b1, 30'h10, 32'h11223344, 4'b0011);
    @(negedge clk);
    check("wr_m1_gnt", 32'(rr_m1_gnt), 32'h1);
    check("wr_mem_we", 32'(rr_mem_we), 32'h1);
    check("wr_mem_wstrb", 32'(rr_mem_wstrb), 32'h3);
    check("wr_mem_wdata", rr_mem_wdata, 32'h11223344);
    ref_write(30'h10, 32'h11223344, 4'b0011);
    tick();
    m1_req = 1'b0;
    drive_m0(1'b1, 1'b0, 30'h10, 32'h0, 4'h0);
    push(1'b0, 32'hAABB3344);
    tick();
    // read in N, full write to the same word in N+1: read sees old data
    drive_m0(1'b1, 1'b0, 30'h20, 32'h0, 4'h0);
    push(1'b0, ref_mem[8'h20]);
    tick();
    m0_req = 1'b0;
    drive_m1(1'b1, 1'b1, 30'h20, 32'hCAFEF00D, 4'b1111);
    ref_write(30'h20, 32'hCAFEF00D, 4'b1111);
    tick();
    m1_req = 1'b0;
    drive_m0(1'b1, 1'b0, 30'h20, 32'h0, 4'h0);
    push(1'b0, 32'hCAFEF00D);
    tick();
    m0_req = 1'b0;
    tick();
    tick();
    check("wr_err", 32'(rr_err), 32'h0);

    // ---- reset asserted while a read response is due ----
    drive_m0(1'b1, 1'b0, 30'h40, 32'h0, 4'h0);
    @(negedge clk);
    check("mr_m0_gnt", 32'(rr_m0_gnt), 32'h1);
    tick();
    m0_req = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    check("mr_rresp", {30'b0, rr_m1_rresp, rr_m0_rresp}, 32'h0);
    check("mr_rdata", rr_m0_rdata | rr_m1_rdata, 32'h0);
    check("mr_err", 32'(rr_err), 32'h0);
    check("mr_gnt_ready", {29'b0, rr_mem_ready, rr_m1_gnt, rr_m0_gnt}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("mr_err_after", 32'(rr_err), 32'h0);

    // ---- missing read response sets err ----
    drive_m0(1'b1, 1'b0, 30'h40, 32'h0, 4'h0);
    tick();
    m0_req     = 1'b0;
    drop_rresp = 1'b1;
    @(negedge clk);
    check("miss_m0_rresp", 32'(rr_m0_rresp), 32'h0);
    tick();
    drop_rresp = 1'b0;
    @(negedge clk);
    check("miss_err", 32'(rr_err), 32'h1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("miss_err_cleared", 32'(rr_err), 32'h0);
    tick();

    // ---- spurious response sets err, which stays set ----
    force_rresp = 1'b1;
    @(negedge clk);
    check("spur_rresp", {30'b0, rr_m1_rresp, rr_m0_rresp}, 32'h0);
    tick();
    force_rresp = 1'b0;
    @(negedge clk);
    check("spur_err", 32'(rr_err), 32'h1);
    repeat (3) tick();
    @(negedge clk);
    check("spur_err_sticky", 32'(rr_err), 32'h1);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("spur_err_reset", 32'(rr_err), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
